// File: rtl/lcd_cmd_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_sched_pkg: shared types/constants for the LCD command scheduler |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_WAIT      = 3'd5,
    ST_IDLE      = 3'd6
  } state_t;

  localparam logic [7:0] INIT_BYTE_0 = 8'h38;
  localparam logic [7:0] INIT_BYTE_1 = 8'h0C;
  localparam logic [7:0] INIT_BYTE_2 = 8'h01;
  localparam logic [7:0] INIT_BYTE_3 = 8'h06;

  localparam int unsigned LCD_DATA_MSB = 7;
  localparam int unsigned LCD_RS_BIT   = 8;
  localparam int unsigned LCD_RW_BIT   = 9;
  localparam int unsigned LCD_EN_BIT   = 10;
  localparam int unsigned LCD_ON_BIT   = 11;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    b = INIT_BYTE_0;
    case (idx)
      2'd0: b = INIT_BYTE_0;
      2'd1: b = INIT_BYTE_1;
      2'd2: b = INIT_BYTE_2;
      2'd3: b = INIT_BYTE_3;
      default: b = INIT_BYTE_0;
    endcase
    return b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_cmd_scheduler_if: single-byte write request channel            |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface lcd_cmd_scheduler_if;
  logic       valid;
  logic       rs;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output rs, output data, input ready);
  modport slave  (input valid, input rs, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_scheduler_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_rr_arbiter: 2-way round-robin arbiter, bit 0 = A, bit 1 = B     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcd_rr_arbiter (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       enable,
  input  wire logic [1:0] req,
  output logic      [1:0] grant
);

  // 1 = B was granted last; resets to B so that A wins the first contention.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // A grant is only raised for a valid request, so any grant is a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_cmd_scheduler: HD44780 init, 2-way write arbitration, bus timing|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcd_cmd_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 3,
  parameter int unsigned PULSE_CYC      = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000,
  parameter int unsigned INIT_WAIT_CYC  = 750000
) (
  input  wire logic             clk_clk,
  input  wire logic             reset_reset,
  lcd_cmd_scheduler_if.slave    a,
  lcd_cmd_scheduler_if.slave    b,
  output logic           [11:0] lcd_bus,
  output logic                  init_done,
  output logic                  busy
);

  localparam int unsigned MAX_0   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_1   = (MAX_0 > CMD_WAIT_CYC) ? MAX_0 : CMD_WAIT_CYC;
  localparam int unsigned MAX_2   = (MAX_1 > CLEAR_WAIT_CYC) ? MAX_1 : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_2 > INIT_WAIT_CYC) ? MAX_2 : INIT_WAIT_CYC;
  localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

  // Each timed state loads N-1 and leaves when the counter reads zero: N cycles.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_WAIT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       init_idx;
  logic             cur_rs;
  logic [7:0]       cur_data;
  logic [1:0]       grant;
  logic             arb_en;
  logic             fire;
  logic             cnt_zero;

  assign arb_en   = (state == ST_IDLE) && init_done;
  assign fire     = |grant;
  assign cnt_zero = (cnt == '0);
  assign busy     = (state != ST_IDLE);
  assign a.ready  = grant[0];
  assign b.ready  = grant[1];

  lcd_rr_arbiter u_arb (
    .clk    (clk_clk),
    .rst    (reset_reset),
    .enable (arb_en),
    .req    ({b.valid, a.valid}),
    .grant  (grant)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= ST_INIT_WAIT;
      cnt       <= INIT_LD;
      init_idx  <= 2'd0;
      init_done <= 1'b0;
      cur_rs    <= 1'b0;
      cur_data  <= 8'h00;
      lcd_bus   <= 12'h000;
    end else begin
      // Bus mirrors the state one cycle later, so EN rises SETUP_CYC+1 after the load.
      lcd_bus[LCD_DATA_MSB:0] <= cur_data;
      lcd_bus[LCD_RS_BIT]     <= cur_rs;
      lcd_bus[LCD_RW_BIT]     <= 1'b0;
      lcd_bus[LCD_EN_BIT]     <= (state == ST_PULSE);
      lcd_bus[LCD_ON_BIT]     <= 1'b1;

      case (state)
        ST_INIT_WAIT: begin
          if (cnt_zero) state <= ST_INIT_LOAD;
          else          cnt   <= cnt - CNT_W'(1);
        end
        ST_INIT_LOAD: begin
          cur_rs   <= 1'b0;
          cur_data <= init_byte(init_idx);
          cnt      <= SETUP_LD;
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            cnt   <= PULSE_LD;
            state <= ST_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            cnt   <= SETUP_LD;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            cnt   <= is_clear_home(cur_rs, cur_data) ? CLEAR_LD : CMD_LD;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else if (init_done) begin
            state <= ST_IDLE;
          end else if (init_idx == 2'd3) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            init_idx <= init_idx + 2'd1;
            state    <= ST_INIT_LOAD;
          end
        end
        ST_IDLE: begin
          if (fire) begin
            cur_rs   <= grant[1] ? b.rs : a.rs;
            cur_data <= grant[1] ? b.data : a.data;
            cnt      <= SETUP_LD;
            state    <= ST_SETUP;
          end
        end
        default: begin
          cnt   <= INIT_LD;
          state <= ST_INIT_WAIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lcd_cmd_scheduler: directed + randomized bench, timing model    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lcd_cmd_scheduler;

  localparam int S  = 2;
  localparam int P  = 4;
  localparam int CW = 10;
  localparam int CL = 40;
  localparam int IW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_cmd_scheduler_if a_if ();
  lcd_cmd_scheduler_if b_if ();
  logic [11:0] lcd_bus;
  logic        init_done;
  logic        busy;

  lcd_cmd_scheduler #(
    .SETUP_CYC      (S),
    .PULSE_CYC      (P),
    .CMD_WAIT_CYC   (CW),
    .CLEAR_WAIT_CYC (CL),
    .INIT_WAIT_CYC  (IW)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .a           (a_if),
    .b           (b_if),
    .lcd_bus     (lcd_bus),
    .init_done   (init_done),
    .busy        (busy)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } req_t;

  typedef struct {
    int         rise;
    logic       rs;
    logic [7:0] data;
  } pulse_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         free_at = 0;
  int         done_at = 0;
  int         rel_at = 0;
  logic       last_b = 1'b1;
  req_t       qa[$];
  req_t       qb[$];
  pulse_t     exp_q[$];
  logic [7:0] seen[$];
  logic [7:0] init_b[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? CL : CW;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    if ($urandom_range(0, 3) == 0) begin
      r.rs   = 1'b0;
      r.data = 8'($urandom_range(1, 3));
    end else begin
      r.rs   = 1'($urandom_range(0, 1));
      r.data = 8'($urandom);
    end
    return r;
  endfunction

  task automatic drive();
    a_if.valid = (qa.size() > 0);
    a_if.rs    = (qa.size() > 0) ? qa[0].rs : 1'b0;
    a_if.data  = (qa.size() > 0) ? qa[0].data : 8'h00;
    b_if.valid = (qb.size() > 0);
    b_if.rs    = (qb.size() > 0) ? qb[0].rs : 1'b0;
    b_if.data  = (qb.size() > 0) ? qb[0].data : 8'h00;
  endtask

  // One clock: check readies/status against the schedule, predict any grant.
  task automatic step();
    logic   idle;
    logic   av;
    logic   bv;
    logic   ea;
    logic   eb;
    pulse_t p;
    @(negedge clk);
    ea = 1'b0;
    eb = 1'b0;
    if (!rst) begin
      idle = (cyc >= free_at);
      av   = (qa.size() > 0);
      bv   = (qb.size() > 0);
      ea   = idle && av && (!bv || last_b);
      eb   = idle && bv && (!av || !last_b);
      chk("a_ready", a_if.ready, ea);
      chk("b_ready", b_if.ready, eb);
      chk("busy", busy, !idle);
      chk("init_done", init_done, cyc >= done_at);
      if (ea || eb) begin
        p.rise  = cyc + 1 + S + 1;
        p.rs    = ea ? qa[0].rs : qb[0].rs;
        p.data  = ea ? qa[0].data : qb[0].data;
        exp_q.push_back(p);
        free_at = cyc + 1 + S + P + S + wait_of(p.rs, p.data);
        last_b  = eb;
      end
    end
    @(posedge clk);
    #1;
    if (ea) qa.delete(0);
    if (eb) qb.delete(0);
    drive();
  endtask

  task automatic do_reset();
    int     l;
    pulse_t p;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_bus", lcd_bus, 12'h000);
      chk("rst_init_done", init_done, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_a_ready", a_if.ready, 1'b0);
      chk("rst_b_ready", b_if.ready, 1'b0);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    rel_at = cyc + 1;
    last_b = 1'b1;
    exp_q.delete();
    l = rel_at + IW;
    for (int k = 0; k < 4; k++) begin
      p.rise = l + S + 1;
      p.rs   = 1'b0;
      p.data = init_b[k];
      exp_q.push_back(p);
      if (k < 3) l = l + S + P + S + wait_of(1'b0, init_b[k]) + 1;
      else       free_at = l + S + P + S + wait_of(1'b0, init_b[k]);
    end
    done_at = free_at;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || exp_q.size() > 0 || cyc < free_at) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", n < budget, 1'b1);
    repeat (2) step();
  endtask

  // Bus monitor: every EN pulse must match the next predicted write.
  logic       prev_en = 1'b0;
  int         rise_c = 0;
  logic [8:0] held = 9'h000;
  always @(negedge clk) begin
    pulse_t p;
    if (rst || cyc < rel_at) begin
      prev_en = 1'b0;
    end else begin
      chk("on_bit", lcd_bus[11], 1'b1);
      chk("rw_bit", lcd_bus[9], 1'b0);
      if (lcd_bus[10] && !prev_en) begin
        rise_c = cyc;
        held   = lcd_bus[8:0];
        seen.push_back(lcd_bus[7:0]);
        if (exp_q.size() == 0) begin
          chk("unexpected_en", 1'b1, 1'b0);
        end else begin
          p = exp_q.pop_front();
          chk("en_rise_cycle", cyc, p.rise);
          chk("en_data", lcd_bus[7:0], p.data);
          chk("en_rs", lcd_bus[8], p.rs);
        end
      end else if (!lcd_bus[10] && prev_en) begin
        chk("en_width", cyc - rise_c, P);
        chk("hold_data_rs", lcd_bus[8:0], held);
      end
      prev_en = lcd_bus[10];
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int   base;
    int   cnt77;
    init_b[0] = 8'h38;
    init_b[1] = 8'h0C;
    init_b[2] = 8'h01;
    init_b[3] = 8'h06;
    drive();

    // Power-on initialisation
    do_reset();
    step();
    chk("on_after_release", lcd_bus[11], 1'b1);
    run_until_idle(400);
    chk("init_count", seen.size(), 4);
    for (int k = 0; k < 4; k++) chk("init_byte", seen[k], init_b[k]);
    chk("init_done_set", init_done, 1'b1);

    // Single data write from A
    r.rs = 1'b1; r.data = 8'h41; qa.push_back(r); drive();
    run_until_idle(200);
    chk("a41_data", seen[seen.size()-1], 8'h41);

    // Clear command from B (long wait)
    r.rs = 1'b0; r.data = 8'h01; qb.push_back(r); drive();
    run_until_idle(200);
    chk("b01_data", seen[seen.size()-1], 8'h01);

    // Continuous contention: strict alternation starting with A
    base = seen.size();
    for (int i = 0; i < 2; i++) begin
      r.rs = 1'b1; r.data = 8'h31; qa.push_back(r);
      r.rs = 1'b1; r.data = 8'h32; qb.push_back(r);
    end
    drive();
    run_until_idle(400);
    chk("alt_count", seen.size() - base, 4);
    chk("alt0", seen[base],   8'h31);
    chk("alt1", seen[base+1], 8'h32);
    chk("alt2", seen[base+2], 8'h31);
    chk("alt3", seen[base+3], 8'h32);

    // Normal command from A (short wait)
    r.rs = 1'b0; r.data = 8'h80; qa.push_back(r); drive();
    run_until_idle(200);
    chk("a80_data", seen[seen.size()-1], 8'h80);

    // Randomized traffic with occasional withdrawals
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: qa.push_back(rand_req());
        1: qb.push_back(rand_req());
        default: begin
          qa.push_back(rand_req());
          qb.push_back(rand_req());
        end
      endcase
      drive();
      repeat ($urandom_range(0, 25)) step();
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) qa.delete();
        else                           qb.delete();
        drive();
      end
    end
    run_until_idle(6000);

    // Reset during PULSE with A already requesting
    r.rs = 1'b1; r.data = 8'h77; qb.push_back(r); drive();
    begin
      int n;
      n = 0;
      while (!lcd_bus[10] && n < 100) begin
        step();
        n++;
      end
    end
    chk("reached_pulse", lcd_bus[10], 1'b1);
    r.rs = 1'b1; r.data = 8'h5A; qa.push_back(r); drive();
    base = seen.size();
    do_reset();
    run_until_idle(600);
    chk("post_reset_count", seen.size() - base, 5);
    cnt77 = 0;
    for (int i = base; i < seen.size(); i++) if (seen[i] == 8'h77) cnt77++;
    chk("stale_byte_gone", cnt77, 0);
    chk("a_after_init", seen[seen.size()-1], 8'h5A);
    chk("final_exp_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
